// File: rtl/fb_pkg.sv
// Shared constants, FSM state encoding and FIFO entry type for the framebuffer pixel writer.
package fb_pkg;

    localparam int unsigned H_RES_DEFAULT  = 800;
    localparam int unsigned V_RES_DEFAULT  = 600;
    localparam int unsigned FRAME_PIXELS   = H_RES_DEFAULT * V_RES_DEFAULT;
    localparam int unsigned ADDR_W_DEFAULT = 20;
    localparam int unsigned CNT_W          = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        SWAP   = 2'd3
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [7:0]                data;
    } fb_entry_t;

    // Saturating increment for the per-frame write counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of two.
module fb_write_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_push = push && ((cnt != FULL_COUNT) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/fb_pixel_writer.sv
// Turns the rasterizer pixel stream into single-beat framebuffer writes and owns the
// front/back buffer swap at the end of each frame.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEFAULT,
    parameter int unsigned V_RES      = V_RES_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       in_x,
    input  logic [10:0]       in_y,
    input  logic [7:0]        in_data,
    input  logic              in_draw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              raster_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              front_buffer,
    output logic              frame_done,
    output logic [19:0]       frame_pixels
);

    localparam int unsigned       CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [10:0]       X_LIM      = 11'(H_RES);
    localparam logic [10:0]       Y_LIM      = 11'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A    = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] UPPER_BASE = ADDR_W'(H_RES * V_RES);
    localparam logic [CW:0]       DEPTH_LIM  = (CW + 1)'(FIFO_DEPTH);

    fb_state_t         state_q;
    fb_state_t         state_d;
    logic              raster_q;
    logic              rise;
    logic              accept;
    logic              keep;

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_row;
    logic [10:0]       s1_x;
    logic [7:0]        s1_data;
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [7:0]        s2_data;
    logic [ADDR_W-1:0] back_base;

    fb_entry_t         push_entry;
    fb_entry_t         head_entry;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;

    logic              pipe_empty;
    logic              swap_now;
    logic              mem_fire;
    logic [CNT_W-1:0]  wr_count;

    // In-flight pipeline beats are counted so a FIFO slot is reserved for every accepted pixel.
    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(s1_valid) + (CW + 1)'(s2_valid);
    assign in_ready  = !reset && (state_q != DRAIN) && (occupancy < DEPTH_LIM);
    assign accept    = in_valid && in_ready;
    assign keep      = accept && in_draw && (in_x < X_LIM) && (in_y < Y_LIM);
    assign rise      = raster_done && !raster_q;
    assign back_base = front_buffer ? '0 : UPPER_BASE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_x     <= '0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_row  <= ADDR_W'(in_y) * H_RES_A;
                s1_x    <= in_x;
                s1_data <= in_data;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr <= back_base + s1_row + ADDR_W'(s1_x);
                s2_data <= s1_data;
            end
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.addr = ADDR_W_DEFAULT'(s2_addr);
        push_entry.data = s2_data;
    end

    fb_write_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s2_valid),
        .push_data (push_entry),
        .pop       (mem_fire),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head is masked while empty so the write port reads zero rather than stale storage.
    assign mem_valid = !fifo_empty;
    assign mem_addr  = mem_valid ? ADDR_W'(head_entry.addr) : '0;
    assign mem_data  = mem_valid ? head_entry.data : '0;
    assign mem_fire  = mem_valid && mem_ready;

    assign pipe_empty = !s1_valid && !s2_valid && fifo_empty;
    assign swap_now   = (state_q == DRAIN) && pipe_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = rise ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (rise) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                // A beat taken during the swap cycle already belongs to the next frame.
                if (accept) begin
                    state_d = rise ? DRAIN : ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            raster_q     <= 1'b0;
            frame_done   <= 1'b0;
            front_buffer <= 1'b0;
            frame_pixels <= '0;
            wr_count     <= '0;
        end else begin
            state_q    <= state_d;
            raster_q   <= raster_done;
            frame_done <= swap_now;
            if (swap_now) begin
                front_buffer <= !front_buffer;
                frame_pixels <= wr_count;
                wr_count     <= '0;
            end else if (mem_fire) begin
                wr_count <= sat_inc(wr_count);
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: vector table for address mapping plus hand-written
// sequences for back-pressure, buffer swap and reset during drain.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic [7:0]  in_data;
    logic        in_draw;
    logic        in_valid;
    logic        in_ready;
    logic        raster_done;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        front_buffer;
    logic        frame_done;
    logic [19:0] frame_pixels;

    fb_pixel_writer dut (
        .clk          (clk),
        .reset        (reset),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_data      (in_data),
        .in_draw      (in_draw),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .raster_done  (raster_done),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .front_buffer (front_buffer),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  data;
        logic        draw;
        logic        exp_write;
        logic [19:0] exp_addr;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulse_cnt = 0;
    int          stall_err = 0;
    logic [27:0] act_q [$];
    logic        hold_pending = 1'b0;
    logic [19:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;

    int          base;
    int          p0;
    int          first_drop;
    int          idx;
    int          cyc;
    logic        ok;
    logic        acc;
    logic        found;
    logic        seen_mv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Records write handshakes, frame_done pulses and head stability under back-pressure.
    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && (!mem_valid || mem_addr !== hold_addr || mem_data !== hold_data))
                stall_err++;
            hold_pending = mem_valid && !mem_ready;
            hold_addr    = mem_addr;
            hold_data    = mem_data;
            if (mem_valid && mem_ready) act_q.push_back({mem_addr, mem_data});
            if (frame_done) pulse_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [10:0] x, input logic [10:0] y, input logic [7:0] d,
                             input logic dr, output logic accepted);
        in_x = x;
        in_y = y;
        in_data = d;
        in_draw = dr;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name);
        for (int k = 0; k < 500 && act_q.size() < target; k++) @(negedge clk);
        check(name, act_q.size(), target);
    endtask

    task automatic wait_pulse(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = frame_done;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_x = '0;
        in_y = '0;
        in_data = '0;
        in_draw = 1'b0;
        in_valid = 1'b0;
        raster_done = 1'b0;
        mem_ready = 1'b0;

        vecs[0] = '{11'd5,    11'd2,    8'h3C, 1'b1, 1'b1, 20'd481605};
        vecs[1] = '{11'd0,    11'd0,    8'h11, 1'b1, 1'b1, 20'd480000};
        vecs[2] = '{11'd799,  11'd599,  8'hFF, 1'b1, 1'b1, 20'd959999};
        vecs[3] = '{11'd0,    11'd0,    8'h22, 1'b0, 1'b0, 20'd0};
        vecs[4] = '{11'd800,  11'd10,   8'h33, 1'b1, 1'b0, 20'd0};
        vecs[5] = '{11'd10,   11'd600,  8'h44, 1'b1, 1'b0, 20'd0};
        vecs[6] = '{11'd2047, 11'd2047, 8'h55, 1'b1, 1'b0, 20'd0};
        vecs[7] = '{11'd799,  11'd0,    8'h66, 1'b1, 1'b1, 20'd480799};
        vecs[8] = '{11'd0,    11'd599,  8'h77, 1'b1, 1'b1, 20'd959200};
        vecs[9] = '{11'd123,  11'd45,   8'h88, 1'b1, 1'b1, 20'd516123};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_front", front_buffer, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_pixels", frame_pixels, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        tick();
        reset = 1'b0;

        // raster_done with no pixels: ignored
        raster_done = 1'b1;
        repeat (5) tick();
        raster_done = 1'b0;
        repeat (3) tick();
        check("empty_frame_pulses", pulse_cnt, 0);
        check("empty_frame_front", front_buffer, 0);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        tick();

        // Vector table: address mapping, drop rules and N+3 latency
        mem_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            send_beat(vecs[v].x, vecs[v].y, vecs[v].data, vecs[v].draw, ok);
            check($sformatf("vec%0d_accepted", v), ok, 1);
            @(negedge clk);
            check($sformatf("vec%0d_n1_valid", v), mem_valid, 0);
            @(negedge clk);
            check($sformatf("vec%0d_n2_valid", v), mem_valid, 0);
            @(negedge clk);
            check($sformatf("vec%0d_n3_valid", v), mem_valid, vecs[v].exp_write);
            if (vecs[v].exp_write) begin
                check($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
                check($sformatf("vec%0d_data", v), mem_data, vecs[v].data);
            end
            @(negedge clk);
            check($sformatf("vec%0d_popped", v), mem_valid, 0);
            tick();
        end
        check("table_frame_pixels", frame_pixels, 0);

        // 100-pixel stream with 30 cycles of memory stall
        base = act_q.size();
        idx = 0;
        cyc = 0;
        first_drop = -1;
        while (idx < 100 && cyc < 1000) begin
            mem_ready = (cyc >= 30);
            in_valid = 1'b1;
            in_x = 11'(idx);
            in_y = 11'(idx % 7);
            in_data = 8'(idx);
            in_draw = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (!acc && first_drop < 0) first_drop = idx;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        mem_ready = 1'b1;
        check("stream_all_accepted", idx, 100);
        check("stream_first_drop", first_drop, 16);
        wait_writes(base + 100, "stream_write_count");
        for (int i = 0; i < 100; i++) begin
            if (base + i < act_q.size())
                check($sformatf("stream_write%0d", i), act_q[base + i],
                      {20'(480000 + (i % 7) * 800 + i), 8'(i)});
        end
        check("stream_hold_stable", stall_err, 0);

        // Close frame 1: 6 table writes + 100 stream writes
        p0 = pulse_cnt;
        raster_done = 1'b1;
        wait_pulse(found);
        check("frame1_pulse_seen", found, 1);
        check("frame1_front", front_buffer, 1);
        check("frame1_pixels", frame_pixels, 106);
        @(negedge clk);
        check("frame1_pulse_width", frame_done, 0);
        raster_done = 1'b0;
        repeat (4) tick();
        check("frame1_pulse_count", pulse_cnt - p0, 1);

        // Fresh frame of 10 pixels, drained under back-pressure
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("reset2_front", front_buffer, 0);
        base = act_q.size();
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            send_beat(11'(i), 11'd1, 8'(i + 1), 1'b1, ok);
            check($sformatf("f2_beat%0d_accepted", i), ok, 1);
        end
        raster_done = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("drain_in_ready%0d", k), in_ready, 0);
        end
        check("drain_front", front_buffer, 0);
        check("drain_no_pulse", pulse_cnt - p0, 0);
        tick();
        mem_ready = 1'b1;
        wait_pulse(found);
        check("frame2_pulse_seen", found, 1);
        check("frame2_front", front_buffer, 1);
        check("frame2_pixels", frame_pixels, 10);
        @(negedge clk);
        check("frame2_pulse_width", frame_done, 0);
        raster_done = 1'b0;
        repeat (4) tick();
        check("frame2_pulse_count", pulse_cnt - p0, 1);
        check("frame2_write_count", act_q.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < act_q.size())
                check($sformatf("frame2_write%0d", i), act_q[base + i],
                      {20'(480800 + i), 8'(i + 1)});
        end

        // Next frame targets buffer 0
        base = act_q.size();
        send_beat(11'd0, 11'd0, 8'hAB, 1'b1, ok);
        check("f3_accepted", ok, 1);
        wait_writes(base + 1, "f3_write_count");
        if (base < act_q.size()) check("f3_write", act_q[base], {20'd0, 8'hAB});

        // Reset in DRAIN with 5 entries pending
        mem_ready = 1'b0;
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            send_beat(11'(i + 10), 11'd3, 8'(i + 40), 1'b1, ok);
        end
        repeat (4) tick();
        raster_done = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("e_drain_in_ready", in_ready, 0);
        check("e_pending_valid", mem_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("e_rst_mem_valid", mem_valid, 0);
        check("e_rst_in_ready", in_ready, 0);
        check("e_rst_front", front_buffer, 0);
        check("e_rst_frame_done", frame_done, 0);
        check("e_rst_frame_pixels", frame_pixels, 0);
        check("e_rst_mem_addr", mem_addr, 0);
        repeat (2) tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        seen_mv = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_valid) seen_mv = 1'b1;
        end
        check("e_no_stale_writes", seen_mv, 0);
        check("e_no_pulse", pulse_cnt - p0, 0);
        check("e_front_after", front_buffer, 0);
        check("e_idle_in_ready", in_ready, 1);
        check("final_hold_stable", stall_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
